seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digit positions (2..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 3, consecutive identical samples required before capture (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port leds  input  8  segment pattern of the currently selected digit (bit 7 unused-in-decode but compared for stability).
REQ-006 SHALL have port dig_sel  input  NUM_DIGITS  active-high digit select, bit i = digit i.
REQ-007 SHALL have port bcd  output  4*NUM_DIGITS  last complete frame, digit i at bits [4i+3:4i].
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when bcd updates.
REQ-009 SHALL have port err  output  1  at least one undecodable pattern in the frame just published.
REQ-010 SHALL have port err_digit  output  3  lowest digit index holding an undecodable pattern in the published frame, 0 when err=0.

Function
REQ-011 SHALL decode leds as: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 4F->A (E glyph), 05->B (r glyph), 00->F (blank); any other pattern->E with error flag.
REQ-012 SHALL treat dig_sel as valid only when exactly one bit set; zero or multiple bits = invalid.
REQ-013 SHALL implement FSM states WAIT_SEL, SETTLE, HOLD.
REQ-014 WAIT_SEL: on valid dig_sel, register sel index and leds, counter=1, go SETTLE (or capture immediately if STABLE_CYCLES=1).
REQ-015 SETTLE: each cycle with same dig_sel and same leds increments counter; when counter reaches STABLE_CYCLES, capture that cycle and go HOLD.
REQ-016 SETTLE: leds change with same dig_sel -> reload leds, counter=1, stay SETTLE.
REQ-017 SETTLE/HOLD: dig_sel changes to another valid one-hot -> reload, counter=1, SETTLE; invalid dig_sel -> WAIT_SEL, counter cleared.
REQ-018 HOLD: no further capture of the same digit until dig_sel changes.
REQ-019 Capture SHALL write decoded code and error bit to staging slot of the selected digit and set its captured bit; re-capture of an already-captured digit in the same frame overwrites the slot.
REQ-020 When all NUM_DIGITS captured bits are set, the next cycle SHALL copy staging to bcd, set err/err_digit from staging error bits, pulse frame_valid, and clear all captured bits.
REQ-021 A capture occurring in the same cycle as frame publish SHALL be retained as first capture of the next frame.
REQ-022 bcd, err, err_digit SHALL hold between publishes.
REQ-023 Latency: frame_valid exactly 1 cycle after the capture that completes the frame.

Reset
REQ-024 rst_n low SHALL asynchronously force FSM=WAIT_SEL, counter=0, captured bits=0, staging=0, bcd=0, frame_valid=0, err=0, err_digit=0.
REQ-025 Reset mid-frame SHALL discard partial frame; no frame_valid until a full new frame is captured.

Structure
REQ-026 Shared package seg_scan_pkg SHALL hold segment pattern constants, code constants (CODE_E_GLYPH=A, CODE_R=B, CODE_ERR=E, CODE_BLANK=F) and FSM state enum.
REQ-027 Decode SHALL be one combinational sub-module seg_decode (leds in, 4-bit code and error out), instantiated once.

Verification
REQ-028 NUM_DIGITS=4, STABLE_CYCLES=3: scan digits 0..3 with 30,6D,79,33, 4 cycles each -> one frame_valid, bcd=16'h4321, err=0.
REQ-029 Glitch: digit 1 shows 7E 2 cycles then 7F 3 cycles -> digit 1 captured as 8, never 0.
REQ-030 dig_sel=0011 for 5 cycles, and dig_sel=0 for 5 cycles -> no capture, FSM in WAIT_SEL, no frame_valid.
REQ-031 Digit 2 shows 01 in full frame -> bcd[11:8]=E, err=1, err_digit=2; next clean frame -> err=0, err_digit=0.
REQ-032 Assert rst_n low after 3 of 4 digits captured, release, scan full frame -> single frame_valid only after all 4 new captures; bcd=0 until then.
REQ-033 Patterns 4F,05,00 on digits 0..2 plus 7B on digit 3 -> bcd=16'h9FBA, err=0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the segment scan capture block: raw segment
// patterns, decoded code values and the capture FSM state encoding.
package seg_scan_pkg;

  // Seven-segment patterns as seen on leds[6:0] (bit 6 = segment a).
  localparam logic [6:0] SEG_0       = 7'h7E;
  localparam logic [6:0] SEG_1       = 7'h30;
  localparam logic [6:0] SEG_2       = 7'h6D;
  localparam logic [6:0] SEG_3       = 7'h79;
  localparam logic [6:0] SEG_4       = 7'h33;
  localparam logic [6:0] SEG_5       = 7'h5B;
  localparam logic [6:0] SEG_6       = 7'h5F;
  localparam logic [6:0] SEG_7       = 7'h70;
  localparam logic [6:0] SEG_8       = 7'h7F;
  localparam logic [6:0] SEG_9       = 7'h7B;
  localparam logic [6:0] SEG_E_GLYPH = 7'h4F;
  localparam logic [6:0] SEG_R       = 7'h05;
  localparam logic [6:0] SEG_BLANK   = 7'h00;

  // Non-numeric codes reported in the bcd output.
  localparam logic [3:0] CODE_E_GLYPH = 4'hA;
  localparam logic [3:0] CODE_R       = 4'hB;
  localparam logic [3:0] CODE_ERR     = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  // Per-digit capture FSM.
  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment to code decoder. Unknown patterns map to
// CODE_ERR and raise the undecodable flag.
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       code_err
);

  // Pattern lookup; anything not in the table is flagged.
  always_comb begin
    code     = CODE_ERR;
    code_err = 1'b0;
    case (seg)
      SEG_0:       code = 4'h0;
      SEG_1:       code = 4'h1;
      SEG_2:       code = 4'h2;
      SEG_3:       code = 4'h3;
      SEG_4:       code = 4'h4;
      SEG_5:       code = 4'h5;
      SEG_6:       code = 4'h6;
      SEG_7:       code = 4'h7;
      SEG_8:       code = 4'h8;
      SEG_9:       code = 4'h9;
      SEG_E_GLYPH: code = CODE_E_GLYPH;
      SEG_R:       code = CODE_R;
      SEG_BLANK:   code = CODE_BLANK;
      default: begin
        code     = CODE_ERR;
        code_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed seven-segment display: each digit is accepted
// once its select and pattern have been stable for STABLE_CYCLES cycles,
// and a full frame of digits is published as packed BCD-style codes.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              leds,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    frame_valid,
  output logic                    err,
  output logic [2:0]              err_digit
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  state_t                  state_reg;
  logic [NUM_DIGITS-1:0]   sel_reg;
  logic [7:0]              leds_reg;
  logic [7:0]              cnt_reg;
  logic [7:0]              cnt_inc;
  logic [NUM_DIGITS-1:0]   captured_reg;

  logic [3:0]              sel_count;
  logic                    sel_onehot;
  logic                    fresh;
  logic                    capture;
  logic                    publish;

  logic [3:0]              dec_code;
  logic                    dec_err;

  logic [3:0]              stage_code_reg [NUM_DIGITS];
  logic                    stage_err_reg  [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] stage_flat;
  logic [NUM_DIGITS-1:0]   stage_err_flat;
  logic [2:0]              err_first;

  // Decoder always looks at the live pattern; bit 7 only matters for stability.
  seg_decode u_decode (
    .seg      (leds[6:0]),
    .code     (dec_code),
    .code_err (dec_err)
  );

  // Count asserted select lines; exactly one means a usable digit select.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) sel_count = sel_count + 4'd1;
    end
  end

  assign sel_onehot = (sel_count == 4'd1);
  assign publish    = &captured_reg;

  // Decide whether this cycle starts a new observation and whether it captures.
  always_comb begin
    cnt_inc = cnt_reg + 8'd1;
    fresh   = sel_onehot &&
              ((state_reg == WAIT_SEL) ||
               (dig_sel != sel_reg) ||
               ((state_reg == SETTLE) && (leds != leds_reg)));
    if (fresh) begin
      capture = (STABLE_W == 8'd1);
    end else begin
      capture = sel_onehot && (state_reg == SETTLE) && (cnt_inc >= STABLE_W);
    end
  end

  // Stability FSM: track the current select/pattern and count matching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_SEL;
      sel_reg   <= '0;
      leds_reg  <= '0;
      cnt_reg   <= '0;
    end else if (!sel_onehot) begin
      state_reg <= WAIT_SEL;
      cnt_reg   <= '0;
    end else if (fresh) begin
      sel_reg   <= dig_sel;
      leds_reg  <= leds;
      cnt_reg   <= 8'd1;
      state_reg <= capture ? HOLD : SETTLE;
    end else if (state_reg == SETTLE) begin
      cnt_reg <= cnt_inc;
      if (capture) state_reg <= HOLD;
    end
  end

  // Captured bits: a publish clears the set, but a same-cycle capture survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured_reg <= '0;
    end else begin
      captured_reg <= (publish ? '0 : captured_reg) | (capture ? dig_sel : '0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      // Staging slot for digit gi; a repeat capture simply overwrites it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_code_reg[gi] <= '0;
          stage_err_reg[gi]  <= 1'b0;
        end else if (capture && dig_sel[gi]) begin
          stage_code_reg[gi] <= dec_code;
          stage_err_reg[gi]  <= dec_err;
        end
      end

      assign stage_flat[4*gi +: 4] = stage_code_reg[gi];
      assign stage_err_flat[gi]    = stage_err_reg[gi];
    end
  endgenerate

  // Lowest staged digit carrying an undecodable pattern.
  always_comb begin
    err_first = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (stage_err_flat[i]) err_first = 3'(i);
    end
  end

  // Publish the staged frame one cycle after the last digit lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd         <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= '0;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        bcd       <= stage_flat;
        err       <= |stage_err_flat;
        err_digit <= err_first;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: a table of full frames plus
// hand-written sequences for latency, glitches, bad selects and reset.
module tb_seg_scan_capture;
  import seg_scan_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  leds;
  logic [3:0]  dig_sel;
  logic [15:0] bcd;
  logic        frame_valid;
  logic        err;
  logic [2:0]  err_digit;

  int n_cmp;
  int n_bad;
  int fv_count;
  int fv0;

  typedef struct {
    logic [31:0] pats;       // digit d pattern at [8d+7:8d]
    logic [15:0] exp_bcd;
    logic        exp_err;
    logic [2:0]  exp_err_digit;
  } frame_vec_t;

  frame_vec_t vecs [6];

  seg_scan_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .leds        (leds),
    .dig_sel     (dig_sel),
    .bcd         (bcd),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid === 1'b1) fv_count++;
    end
  endtask

  task automatic show(input logic [3:0] sel, input logic [7:0] pat, input int n);
    dig_sel = sel;
    leds    = pat;
    step(n);
  endtask

  task automatic scan_frame(input logic [31:0] pats);
    for (int d = 0; d < 4; d++) begin
      show(4'(1 << d), pats[8*d +: 8], 4);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    fv_count = 0;

    vecs[0] = '{pats: {8'h33, 8'h79, 8'h6D, 8'h30}, exp_bcd: 16'h4321, exp_err: 1'b0, exp_err_digit: 3'd0};
    vecs[1] = '{pats: {8'h7F, 8'h01, 8'h30, 8'h7E}, exp_bcd: 16'h8E10, exp_err: 1'b1, exp_err_digit: 3'd2};
    vecs[2] = '{pats: {8'h7B, 8'h70, 8'h5F, 8'h5B}, exp_bcd: 16'h9765, exp_err: 1'b0, exp_err_digit: 3'd0};
    vecs[3] = '{pats: {8'h7B, 8'h00, 8'h05, 8'h4F}, exp_bcd: 16'h9FBA, exp_err: 1'b0, exp_err_digit: 3'd0};
    vecs[4] = '{pats: {8'h08, 8'hB0, 8'h12, 8'hFE}, exp_bcd: 16'hE1E0, exp_err: 1'b1, exp_err_digit: 3'd1};
    vecs[5] = '{pats: {8'h6D, 8'h6D, 8'h6D, 8'h6D}, exp_bcd: 16'h2222, exp_err: 1'b0, exp_err_digit: 3'd0};

    // Reset state
    rst_n   = 1'b0;
    leds    = 8'h00;
    dig_sel = 4'b0000;
    step(2);
    check("reset_bcd", 32'(bcd), 32'h0);
    check("reset_fv", 32'(frame_valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_err_digit", 32'(err_digit), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Latency: frame_valid exactly one cycle after the completing capture
    fv0 = fv_count;
    show(4'b0001, 8'h30, 4);
    show(4'b0010, 8'h6D, 4);
    show(4'b0100, 8'h79, 4);
    show(4'b1000, 8'h33, 3);
    check("lat_no_fv_at_capture", 32'(frame_valid), 32'h0);
    check("lat_bcd_before_publish", 32'(bcd), 32'h0);
    step(1);
    check("lat_fv_pulse", 32'(frame_valid), 32'h1);
    check("lat_bcd", 32'(bcd), 32'h4321);
    check("lat_err", 32'(err), 32'h0);
    step(1);
    check("lat_fv_one_cycle", 32'(frame_valid), 32'h0);
    check("lat_fv_count", 32'(fv_count - fv0), 32'h1);
    $display("latency frame: bcd=%04h err=%0d", bcd, err);
    show(4'b0000, 8'h00, 2);

    // Table of full frames
    for (int v = 0; v < 6; v++) begin
      fv0 = fv_count;
      scan_frame(vecs[v].pats);
      check($sformatf("vec%0d_fv_count", v), 32'(fv_count - fv0), 32'h1);
      check($sformatf("vec%0d_bcd", v), 32'(bcd), 32'(vecs[v].exp_bcd));
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_err_digit", v), 32'(err_digit), 32'(vecs[v].exp_err_digit));
      $display("frame %0d: pats=%08h bcd=%04h err=%0d err_digit=%0d", v, vecs[v].pats, bcd, err, err_digit);
      show(4'b0000, 8'h00, 2);
    end

    // Outputs hold between publishes
    show(4'b0000, 8'h00, 3);
    check("hold_bcd", 32'(bcd), 32'h2222);
    check("hold_fv", 32'(frame_valid), 32'h0);

    // Glitch on digit 1: 7E for two cycles, then 7F for three
    fv0 = fv_count;
    show(4'b0001, 8'h30, 4);
    show(4'b0010, 8'h7E, 2);
    check("glitch_no_capture", 32'(dut.captured_reg), 32'h1);
    show(4'b0010, 8'h7F, 3);
    check("glitch_captured", 32'(dut.captured_reg), 32'h3);
    show(4'b0100, 8'h6D, 4);
    show(4'b1000, 8'h79, 4);
    check("glitch_fv_count", 32'(fv_count - fv0), 32'h1);
    check("glitch_bcd", 32'(bcd), 32'h3281);
    $display("glitch frame: bcd=%04h", bcd);
    show(4'b0000, 8'h00, 2);

    // Invalid selects: two bits, then none
    fv0 = fv_count;
    show(4'b0011, 8'h30, 5);
    check("multi_sel_state", 32'(dut.state_reg), 32'(WAIT_SEL));
    show(4'b0000, 8'h30, 5);
    check("no_sel_state", 32'(dut.state_reg), 32'(WAIT_SEL));
    check("bad_sel_no_capture", 32'(dut.captured_reg), 32'h0);
    check("bad_sel_no_fv", 32'(fv_count - fv0), 32'h0);
    $display("invalid select: captured=%04b", dut.captured_reg);

    // Reset after three of four digits, then a fresh full frame
    show(4'b0001, 8'h7B, 4);
    show(4'b0010, 8'h7B, 4);
    show(4'b0100, 8'h7B, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bcd", 32'(bcd), 32'h0);
    check("async_rst_state", 32'(dut.state_reg), 32'(WAIT_SEL));
    check("async_rst_captured", 32'(dut.captured_reg), 32'h0);
    dig_sel = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(1);
    fv0 = fv_count;
    show(4'b0001, 8'h30, 4);
    show(4'b0010, 8'h6D, 4);
    show(4'b0100, 8'h79, 4);
    check("post_rst_partial_no_fv", 32'(fv_count - fv0), 32'h0);
    check("post_rst_partial_bcd", 32'(bcd), 32'h0);
    show(4'b1000, 8'h33, 4);
    check("post_rst_fv_count", 32'(fv_count - fv0), 32'h1);
    check("post_rst_bcd", 32'(bcd), 32'h4321);
    $display("post-reset frame: bcd=%04h", bcd);
    show(4'b0000, 8'h00, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
